io_ctrl32: RTL and testbench
============================

IO_CTRL32 -- requirements
Module: io_ctrl32

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 200000: consecutive stable cycles required before a switch change is accepted.
REQ-002 Parameter SCAN_DIV, default 100000: clock cycles per seven-segment digit slot.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 IORead  input  1  I/O load strobe from the control unit (lw to 0xFFFFFC00-0xFFFFFFFF).
REQ-006 IOWrite  input  1  I/O store strobe from the control unit (sw to the same range).
REQ-007 addr_low  input  10  ALU result [9:0]; register select within the I/O page.
REQ-008 wdata  input  32  store data (rt register value).
REQ-009 rdata  output  32  load data to the write-back mux.
REQ-010 switch_raw  input  16  asynchronous board switches.
REQ-011 led  output  16  LED drive, active-high.
REQ-012 seg_an  output  8  digit enables, active-low, bit i = digit i.
REQ-013 seg_out  output  8  segments, active-low, [7]=dp, [6:0]=g,f,e,d,c,b,a.

Function
REQ-014 Register map (addr_low): 0x060 LED (R/W, bits [15:0]); 0x070 SW (R only, debounced switches in [15:0]); 0x080 SEGDATA (R/W, 32 bits, nibble i = digit i); 0x084 SEGMASK (R/W, bits [7:0], 1 = digit lit).
REQ-015 Writes: when IOWrite=1 at a rising edge, the addressed writable register takes the relevant low bits of wdata; upper bits are ignored.
REQ-016 Writes to 0x070 or to unmapped addresses are ignored with no side effect.
REQ-017 Reads are combinational: rdata reflects the addressed register in the same cycle that IORead=1, zero-extended to 32 bits.
REQ-018 rdata is 0 when IORead=0 or the address is unmapped.
REQ-019 If IORead and IOWrite are both 1, the write is performed and rdata shows the pre-edge value.
REQ-020 LED output: led equals the LED register at all times.
REQ-021 Switch path: switch_raw passes through a 2-flop synchronizer to produce sw_sync.
REQ-022 Debounce: a candidate register and a counter track sw_sync; any bit differing from the candidate reloads the candidate and clears the counter.
REQ-023 Debounce acceptance: sw_stable is loaded from the candidate when the counter reaches DEBOUNCE_CYCLES-1; the counter saturates there until the next change.
REQ-024 Debounce glitches: a glitch shorter than DEBOUNCE_CYCLES cycles never reaches sw_stable.
REQ-025 Scan prescaler: counts 0..SCAN_DIV-1 and wraps to 0.
REQ-026 Digit index: a 3-bit index increments on each prescaler wrap, going 7 -> 0.
REQ-027 Enable drive: seg_an = ~(1<<idx) when SEGMASK[idx]=1, else 8'hFF (all off).
REQ-028 Segment decode: seg_out[6:0] is the active-low hex decode of SEGDATA nibble idx, and seg_out[7] is always 1 (dp off).
REQ-029 Decode table: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 B=83 C=C6 D=A1 E=86 F=8E (full seg_out byte, hex).
REQ-030 Display writes: updates to SEGDATA or SEGMASK take effect on the displayed digit in the cycle after the write edge; scan timing is unaffected.

Reset
REQ-031 While rst_n=0, with effect immediate and independent of clock: LED, SEGDATA, SEGMASK, synchronizer flops, candidate, sw_stable, debounce counter, prescaler, and idx all clear to 0.
REQ-032 Outputs during reset: led=0, seg_an=8'hFF, seg_out=8'hC0, rdata=0 unless a read is presented.
REQ-033 Reset during operation: reset asserted mid-debounce or mid-scan discards all progress; after release, counting restarts from 0.

Verification (DEBOUNCE_CYCLES=4, SCAN_DIV=2)
REQ-034 Stimulus: IOWrite, addr 0x060, wdata 0xFFFF_A5A5. Response: led=0xA5A5 after the edge; IORead at 0x060 gives rdata=0x0000_A5A5 in the same cycle.
REQ-035 Stimulus: switch_raw 0 -> 0x00F0 held. Response: SW read stays 0 until exactly 2 sync cycles + 4 stable cycles have elapsed, then reads 0x0000_00F0; a 3-cycle pulse to 0x0001 never appears.
REQ-036 Stimulus: SEGDATA=0x76543210, SEGMASK=0xFF. Response: seg_an steps FE, FD, ..., 7F, FE every 2 cycles, with seg_out C0, F9, A4, B0, 99, 92, 82, F8 respectively.
REQ-037 Stimulus: SEGMASK=0x01. Response: seg_an=FE during idx 0 and FF during idx 1-7.
REQ-038 Stimulus: write to 0x070, and read 0x3FC. Response: SW unchanged; rdata=0.
REQ-039 Stimulus: pulse rst_n low asynchronously mid-scan with LED=0x1234. Response: led=0 and seg_an=FF immediately; after release, idx restarts at 0.

Source files
------------

// File: rtl/io_ctrl32.sv
// Memory-mapped board I/O for the single-cycle CPU: LED register, debounced
// switches and a multiplexed 8-digit seven-segment display.
module io_ctrl32 #(
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter int unsigned SCAN_DIV        = 100000
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        IORead,
    input  logic        IOWrite,
    input  logic [9:0]  addr_low,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [15:0] switch_raw,
    output logic [15:0] led,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_out
);

    localparam logic [9:0] ADDR_LED  = 10'h060;
    localparam logic [9:0] ADDR_SW   = 10'h070;
    localparam logic [9:0] ADDR_SEGD = 10'h080;
    localparam logic [9:0] ADDR_SEGM = 10'h084;

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCW-1:0] SC_MAX = SCW'(SCAN_DIV - 1);

    logic [15:0]    led_q,    led_d;
    logic [31:0]    segd_q,   segd_d;
    logic [7:0]     segm_q,   segm_d;
    logic [15:0]    meta_q,   sync_q;
    logic [15:0]    cand_q,   cand_d;
    logic [15:0]    stable_q, stable_d;
    logic [DBW-1:0] dcnt_q,   dcnt_d;
    logic [SCW-1:0] pre_q,    pre_d;
    logic [2:0]     idx_q,    idx_d;
    logic [3:0]     nib;

    // Register writes; read-only and unmapped addresses fall through untouched.
    always_comb begin
        led_d  = led_q;
        segd_d = segd_q;
        segm_d = segm_q;
        if (IOWrite) begin
            case (addr_low)
                ADDR_LED:  led_d  = wdata[15:0];
                ADDR_SEGD: segd_d = wdata;
                ADDR_SEGM: segm_d = wdata[7:0];
                default:   ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (IORead) begin
            case (addr_low)
                ADDR_LED:  rdata = {16'h0, led_q};
                ADDR_SW:   rdata = {16'h0, stable_q};
                ADDR_SEGD: rdata = segd_q;
                ADDR_SEGM: rdata = {24'h0, segm_q};
                default:   rdata = '0;
            endcase
        end
    end

    // Candidate reloads on any change; stable follows once the counter lands on
    // its top value, and keeps re-latching the same candidate while saturated.
    always_comb begin
        cand_d   = cand_q;
        dcnt_d   = dcnt_q;
        stable_d = stable_q;
        if (sync_q != cand_q) begin
            cand_d = sync_q;
            dcnt_d = '0;
        end else begin
            if (dcnt_q != DB_MAX) dcnt_d = dcnt_q + 1'b1;
            if (dcnt_d == DB_MAX) stable_d = cand_q;
        end
    end

    always_comb begin
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == SC_MAX) begin
            pre_d = '0;
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            led_q    <= '0;
            segd_q   <= '0;
            segm_q   <= '0;
            meta_q   <= '0;
            sync_q   <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            dcnt_q   <= '0;
            pre_q    <= '0;
            idx_q    <= '0;
        end else begin
            led_q    <= led_d;
            segd_q   <= segd_d;
            segm_q   <= segm_d;
            meta_q   <= switch_raw;
            sync_q   <= meta_q;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            dcnt_q   <= dcnt_d;
            pre_q    <= pre_d;
            idx_q    <= idx_d;
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign nib     = segd_q[{idx_q, 2'b00} +: 4];
    assign led     = led_q;
    assign seg_an  = segm_q[idx_q] ? ~(8'b1 << idx_q) : 8'hFF;
    assign seg_out = {1'b1, hex7(nib)};

endmodule

// File: tb/tb_io_ctrl32.sv
// Bench for io_ctrl32 with short debounce/scan constants: register table,
// scan sequence, async reset and debounce corner cases.
module tb_io_ctrl32;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        IORead, IOWrite;
    logic [9:0]  addr_low;
    logic [31:0] wdata, rdata;
    logic [15:0] switch_raw, led;
    logic [7:0]  seg_an, seg_out;

    io_ctrl32 #(.DEBOUNCE_CYCLES(4), .SCAN_DIV(2)) dut (
        .clock(clock), .rst_n(rst_n), .IORead(IORead), .IOWrite(IOWrite),
        .addr_low(addr_low), .wdata(wdata), .rdata(rdata),
        .switch_raw(switch_raw), .led(led), .seg_an(seg_an), .seg_out(seg_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic        re;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [15:0] exp_led;
    } vec_t;

    vec_t        tbl [13];
    logic [31:0] exp_q [$];
    logic [7:0]  DEC [16];
    int          checks = 0;
    int          errors = 0;
    int          n = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        n++;
    endtask

    task automatic sw_read_check(input string nm, input logic [15:0] exp);
        @(negedge clock);
        chk(nm, rdata, {16'h0, exp});
    endtask

    initial begin
        logic [31:0] got;
        int          idx;

        DEC = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        tbl[0]  = '{1'b1, 1'b0, 10'h060, 32'hFFFF_A5A5, 32'h0,         16'hA5A5};
        tbl[1]  = '{1'b0, 1'b1, 10'h060, 32'h0,         32'h0000_A5A5, 16'hA5A5};
        tbl[2]  = '{1'b1, 1'b1, 10'h080, 32'h7654_3210, 32'h0,         16'hA5A5};
        tbl[3]  = '{1'b0, 1'b1, 10'h080, 32'h0,         32'h7654_3210, 16'hA5A5};
        tbl[4]  = '{1'b1, 1'b0, 10'h084, 32'hFFFF_FFFF, 32'h0,         16'hA5A5};
        tbl[5]  = '{1'b0, 1'b1, 10'h084, 32'h0,         32'h0000_00FF, 16'hA5A5};
        tbl[6]  = '{1'b1, 1'b1, 10'h070, 32'h1234_5678, 32'h0,         16'hA5A5};
        tbl[7]  = '{1'b0, 1'b1, 10'h070, 32'h0,         32'h0,         16'hA5A5};
        tbl[8]  = '{1'b0, 1'b1, 10'h3FC, 32'h0,         32'h0,         16'hA5A5};
        tbl[9]  = '{1'b1, 1'b0, 10'h3FC, 32'hDEAD_BEEF, 32'h0,         16'hA5A5};
        tbl[10] = '{1'b0, 1'b0, 10'h060, 32'h0,         32'h0,         16'hA5A5};
        tbl[11] = '{1'b1, 1'b1, 10'h060, 32'h0000_1234, 32'h0000_A5A5, 16'h1234};
        tbl[12] = '{1'b0, 1'b1, 10'h060, 32'h0,         32'h0000_1234, 16'h1234};

        rst_n = 1'b0; IORead = 1'b0; IOWrite = 1'b0;
        addr_low = '0; wdata = '0; switch_raw = '0;
        #3;
        chk("rst_led",     {16'h0, led},    32'h0);
        chk("rst_seg_an",  {24'h0, seg_an}, 32'hFF);
        chk("rst_seg_out", {24'h0, seg_out}, 32'hC0);
        chk("rst_rdata",   rdata,           32'h0);
        #4 rst_n = 1'b1;
        tick();

        // Register table: read value is pre-edge, led is post-edge.
        for (int i = 0; i < 13; i++) begin
            IOWrite = tbl[i].we; IORead = tbl[i].re;
            addr_low = tbl[i].addr; wdata = tbl[i].wd;
            exp_q.push_back(tbl[i].exp_rd);
            @(negedge clock);
            got = exp_q.pop_front();
            chk($sformatf("tbl%0d_rdata", i), rdata, got);
            tick();
            chk($sformatf("tbl%0d_led", i), {16'h0, led}, {16'h0, tbl[i].exp_led});
            IOWrite = 1'b0; IORead = 1'b0;
        end

        // Asynchronous reset mid-cycle with LED=0x1234 and display active.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_led",    {16'h0, led},    32'h0);
        chk("arst_seg_an", {24'h0, seg_an}, 32'hFF);
        #2 rst_n = 1'b1;
        n = 0;
        IORead = 1'b1; addr_low = 10'h080;
        #1 chk("arst_segdata_rd", rdata, 32'h0);

        IORead = 1'b0; IOWrite = 1'b1; addr_low = 10'h080; wdata = 32'h7654_3210;
        tick();
        addr_low = 10'h084; wdata = 32'h0000_00FF;
        @(negedge clock);
        chk("scan_mask0_an",  {24'h0, seg_an},  32'hFF);
        chk("scan_mask0_out", {24'h0, seg_out}, {24'h0, DEC[0]});
        tick();
        IOWrite = 1'b0;

        // Index counted from the reset release: idx = (edges/2) mod 8.
        for (int k = 0; k < 18; k++) begin
            @(negedge clock);
            idx = (n / 2) % 8;
            chk($sformatf("scan%0d_an", k),  {24'h0, seg_an},  {24'h0, ~(8'h01 << idx)});
            chk($sformatf("scan%0d_out", k), {24'h0, seg_out}, {24'h0, DEC[idx]});
            tick();
        end

        IOWrite = 1'b1; addr_low = 10'h084; wdata = 32'h0000_0001;
        tick();
        IOWrite = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            idx = (n / 2) % 8;
            chk($sformatf("mask1_%0d_an", k), {24'h0, seg_an}, (idx == 0) ? 32'hFE : 32'hFF);
            tick();
        end

        // Debounce: 2 sync edges + 4 stable edges before the value is accepted.
        IORead = 1'b1; addr_low = 10'h070;
        switch_raw = 16'h00F0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            sw_read_check($sformatf("deb_edge%0d", k), (k >= 6) ? 16'h00F0 : 16'h0000);
        end

        switch_raw = 16'h0001;
        repeat (3) tick();
        switch_raw = 16'h00F0;
        for (int k = 0; k < 10; k++) begin
            tick();
            sw_read_check($sformatf("glitch%0d", k), 16'h00F0);
        end

        // Reset mid-debounce discards progress; the full delay applies again.
        switch_raw = 16'h0F0F;
        repeat (4) tick();
        #1 rst_n = 1'b0;
        #1 chk("deb_rst_sw", rdata, 32'h0);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            sw_read_check($sformatf("deb_rst_edge%0d", k), (k >= 6) ? 16'h0F0F : 16'h0000);
        end
        IORead = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
